// File: rtl/cdb_pkg.sv
// Shared constants and types for the common data bus arbiter.
// Source indices are fixed: 0 = ALU, 1 = branch ALU, 2 = load/store buffer.
package cdb_pkg;
    localparam int NUM_SRC = 3;
    localparam int TAG_W   = 5;
    localparam int DATA_W  = 32;
    localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [TAG_W-1:0] TAG_FREE = {TAG_W{1'b1}};

    localparam int SRC_ALU = 0;
    localparam int SRC_BR  = 1;
    localparam int SRC_LS  = 2;

    typedef logic [SRC_W-1:0] src_idx_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;

    // NUM_SRC need not be a power of two, so wrap by compare rather than mask.
    function automatic src_idx_t rr_next(input src_idx_t idx);
        return (idx == src_idx_t'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
    endfunction
endpackage

// File: rtl/cdb_if.sv
// Producer-side handshake and CDB broadcast signals of the arbiter.
interface cdb_if
    import cdb_pkg::*;
();
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic [SRC_W-1:0]          cdb_src;
    logic                      busy;

    modport master (
        output src_valid, src_tag, src_data,
        input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, busy
    );

    modport slave (
        input  src_valid, src_tag, src_data,
        output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, busy
    );
endinterface

// File: rtl/cdb_src_fifo.sv
// Two-entry in-order (tag, data) holding FIFO for one result producer.
// The caller guarantees no push when full and no pop when empty.
module cdb_src_fifo
    import cdb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  cdb_entry_t push_entry,
    output cdb_entry_t head,
    output logic [1:0] count
);
    cdb_entry_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter broadcasting one buffered producer result per cycle
// on a registered common data bus, with mispredict flush.
module cdb_arbiter
    import cdb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    cdb_if.slave bus
);
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] src_ready;
    logic [NUM_SRC-1:0] nonempty;
    logic [1:0]         count [NUM_SRC];
    cdb_entry_t         head  [NUM_SRC];

    logic               found;
    src_idx_t           winner;
    src_idx_t           idx;
    src_idx_t           rr_ptr;

    logic               cdb_valid_q;
    logic [TAG_W-1:0]   cdb_tag_q;
    logic [DATA_W-1:0]  cdb_data_q;
    src_idx_t           cdb_src_q;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [TAG_W-1:0] tag_in;
        assign tag_in       = bus.src_tag[g*TAG_W +: TAG_W];
        // Readiness looks only at the registered count: no pass-through when full.
        assign src_ready[g] = (count[g] < 2'd2) && !flush;
        // TAG_FREE results complete the handshake but are never queued.
        assign push[g]      = bus.src_valid[g] && src_ready[g] && (tag_in != TAG_FREE);
        assign pop[g]       = found && (winner == src_idx_t'(g));
        assign nonempty[g]  = (count[g] != 2'd0);

        cdb_src_fifo u_fifo (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .push       (push[g]),
            .pop        (pop[g]),
            .push_entry ('{tag: tag_in, data: bus.src_data[g*DATA_W +: DATA_W]}),
            .head       (head[g]),
            .count      (count[g])
        );
    end

    always_comb begin
        found  = 1'b0;
        winner = rr_ptr;
        idx    = rr_ptr;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && nonempty[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = rr_next(idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= TAG_FREE;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
            rr_ptr      <= '0;
        end else if (flush) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= TAG_FREE;
            cdb_data_q  <= '0;
            rr_ptr      <= '0;
        end else if (found) begin
            cdb_valid_q <= 1'b1;
            cdb_tag_q   <= head[winner].tag;
            cdb_data_q  <= head[winner].data;
            cdb_src_q   <= winner;
            rr_ptr      <= rr_next(winner);
        end else begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= TAG_FREE;
            cdb_data_q  <= '0;
        end
    end

    assign bus.src_ready = src_ready;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_src   = cdb_src_q;
    assign bus.busy      = (|nonempty) || cdb_valid_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: vector table plus hand-written
// sequences for saturation, reset mid-operation and flush.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic clk;
    logic rst;
    logic flush;
    int   checks   = 0;
    int   failures = 0;

    cdb_if bus ();

    cdb_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] tags;
        logic [95:0] data;
        logic        fl;
        logic [2:0]  ready;
        logic        cv;
        logic [4:0]  ct;
        logic [31:0] cd;
        logic [1:0]  cs;
        logic        busy;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic [2:0] valid, input logic [14:0] tags,
                                input logic [95:0] data, input logic fl,
                                input logic [2:0] ready, input logic cv,
                                input logic [4:0] ct, input logic [31:0] cd,
                                input logic [1:0] cs, input logic busy);
        vec_t v;
        v.valid = valid; v.tags = tags; v.data = data; v.fl = fl;
        v.ready = ready; v.cv = cv; v.ct = ct; v.cd = cd; v.cs = cs; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] valid, input logic [14:0] tags,
                         input logic [95:0] data, input logic fl);
        bus.src_valid = valid;
        bus.src_tag   = tags;
        bus.src_data  = data;
        flush         = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_valid"}, {31'd0, bus.cdb_valid}, 32'd0);
        chk({name, "_tag"}, {27'd0, bus.cdb_tag}, 32'h1F);
        chk({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int          next_tag [3];
        int          q [3][$];
        int          bcast;
        int          exp_tag;
        int          s;
        bit          saw_bp;
        logic [2:0]  v;
        logic [2:0]  rdy;
        logic [14:0] tg;
        logic [95:0] dt;

        // idle vectors (tag 0 with valid low) are irrelevant on the inputs
        vecs[0]  = mk(3'b001, {5'd0, 5'd0, 5'd3}, {64'd0, 32'hDEADBEEF}, 0, 3'b111, 0, 5'h1F, 32'h0, 2'd0, 1);
        vecs[1]  = mk(3'b000, 15'd0, 96'd0, 0, 3'b111, 1, 5'd3, 32'hDEADBEEF, 2'd0, 1);
        vecs[2]  = mk(3'b000, 15'd0, 96'd0, 0, 3'b111, 0, 5'h1F, 32'h0, 2'd0, 0);
        vecs[3]  = mk(3'b000, 15'd0, 96'd0, 1, 3'b000, 0, 5'h1F, 32'h0, 2'd0, 0);
        vecs[4]  = mk(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33333333, 32'h22222222, 32'h11111111}, 0, 3'b111, 0, 5'h1F, 32'h0, 2'd0, 1);
        vecs[5]  = mk(3'b000, 15'd0, 96'd0, 0, 3'b111, 1, 5'd1, 32'h11111111, 2'd0, 1);
        vecs[6]  = mk(3'b000, 15'd0, 96'd0, 0, 3'b111, 1, 5'd2, 32'h22222222, 2'd1, 1);
        vecs[7]  = mk(3'b000, 15'd0, 96'd0, 0, 3'b111, 1, 5'd3, 32'h33333333, 2'd2, 1);
        vecs[8]  = mk(3'b000, 15'd0, 96'd0, 0, 3'b111, 0, 5'h1F, 32'h0, 2'd2, 0);
        vecs[9]  = mk(3'b010, {5'd0, 5'h1F, 5'd0}, {32'd0, 32'd5, 32'd0}, 0, 3'b111, 0, 5'h1F, 32'h0, 2'd2, 0);
        for (int i = 10; i < 14; i++)
            vecs[i] = mk(3'b000, 15'd0, 96'd0, 0, 3'b111, 0, 5'h1F, 32'h0, 2'd2, 0);

        // reset with all sources asserting valid
        rst = 1'b1;
        drive(3'b111, 15'd0, 96'd0, 0);
        step();
        step();
        chk("rst_valid", {31'd0, bus.cdb_valid}, 32'd0);
        chk("rst_tag", {27'd0, bus.cdb_tag}, 32'h1F);
        chk("rst_data", bus.cdb_data, 32'd0);
        chk("rst_src", {30'd0, bus.cdb_src}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        drive(3'b000, 15'd0, 96'd0, 0);
        #1;
        chk("rst_ready", {29'd0, bus.src_ready}, 32'h7);

        // single result, flush from idle, contention, TAG_FREE push
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].valid, vecs[i].tags, vecs[i].data, vecs[i].fl);
            #1;
            chk($sformatf("v%0d_ready", i), {29'd0, bus.src_ready}, {29'd0, vecs[i].ready});
            step();
            chk($sformatf("v%0d_cdb_valid", i), {31'd0, bus.cdb_valid}, {31'd0, vecs[i].cv});
            chk($sformatf("v%0d_cdb_tag", i), {27'd0, bus.cdb_tag}, {27'd0, vecs[i].ct});
            chk($sformatf("v%0d_cdb_data", i), bus.cdb_data, vecs[i].cd);
            chk($sformatf("v%0d_cdb_src", i), {30'd0, bus.cdb_src}, {30'd0, vecs[i].cs});
            chk($sformatf("v%0d_busy", i), {31'd0, bus.busy}, {31'd0, vecs[i].busy});
        end

        // all three sources saturating: 10 tags each, scoreboarded per source
        for (int i = 0; i < 3; i++) next_tag[i] = 0;
        bcast  = 0;
        saw_bp = 0;
        for (int c = 0; c < 200 && bcast < 30; c++) begin
            for (int i = 0; i < 3; i++) begin
                v[i]            = (next_tag[i] < 10);
                tg[i*5 +: 5]    = 5'(i * 10 + next_tag[i]);
                dt[i*32 +: 32]  = 32'hC000_0000 | 32'(i * 10 + next_tag[i]);
            end
            drive(v, tg, dt, 0);
            #1;
            rdy = bus.src_ready;
            if (!rdy[0]) saw_bp = 1;
            for (int i = 0; i < 3; i++) begin
                if (v[i] && rdy[i]) begin
                    q[i].push_back(i * 10 + next_tag[i]);
                    next_tag[i]++;
                end
            end
            step();
            if (bus.cdb_valid) begin
                s = int'(bus.cdb_src);
                chk("fair_src", {30'd0, bus.cdb_src}, 32'(bcast % 3));
                exp_tag = -1;
                if (s < 3 && q[s].size() > 0) exp_tag = q[s].pop_front();
                chk("fair_tag", {27'd0, bus.cdb_tag}, 32'(exp_tag));
                chk("fair_data", bus.cdb_data, 32'hC000_0000 | 32'(exp_tag));
                bcast++;
            end
        end
        drive(3'b000, 15'd0, 96'd0, 0);
        chk("fair_count", 32'(bcast), 32'd30);
        chk("fair_backpressure", {31'd0, saw_bp}, 32'd1);
        chk("fair_leftover", 32'(q[0].size() + q[1].size() + q[2].size()), 32'd0);
        step();
        chk_idle("fair_end");

        // reset mid-operation discards the queued result
        drive(3'b001, {10'd0, 5'd6}, {64'd0, 32'h66}, 0);
        step();
        drive(3'b000, 15'd0, 96'd0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("midrst");
        chk("midrst_src", {30'd0, bus.cdb_src}, 32'd0);
        step();
        chk_idle("midrst_after");

        // flush while results are queued and src2 offers tag 7
        drive(3'b011, {5'd0, 5'd8, 5'd4}, {32'd0, 32'h88, 32'h44}, 0);
        step();
        drive(3'b011, {5'd0, 5'd9, 5'd5}, {32'd0, 32'h99, 32'h55}, 0);
        step();
        chk("pre_flush_valid", {31'd0, bus.cdb_valid}, 32'd1);
        chk("pre_flush_tag", {27'd0, bus.cdb_tag}, 32'd4);
        drive(3'b100, {5'd7, 5'd0, 5'd0}, {32'h77, 64'd0}, 1);
        #1;
        chk("flush_ready", {29'd0, bus.src_ready}, 32'd0);
        chk("flush_cycle_tag", {27'd0, bus.cdb_tag}, 32'd4);
        step();
        drive(3'b000, 15'd0, 96'd0, 0);
        chk_idle("post_flush0");
        for (int i = 1; i < 5; i++) begin
            #1;
            chk($sformatf("post_flush%0d_ready", i), {29'd0, bus.src_ready}, 32'h7);
            step();
            chk_idle($sformatf("post_flush%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
